// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - iterative radix-2 restoring divider with signed/unsigned modes
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_orig;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Unsigned WIDTH-bit magnitude, so the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
  end

  // busy/done are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      dvd_orig    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state == CALC) || (state == FIX);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            rem      <= '0;
            quo      <= mag(dividend, signed_op);
            dvs_mag  <= mag(divisor, signed_op);
            dvd_orig <= dividend;
            neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_op & dividend[WIDTH-1];
            zero_div <= (divisor == '0);
            count    <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + CW'(1);
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          // A zero divisor bypasses sign correction: all-ones quotient, untouched dividend.
          quotient    <= zero_div ? '1 : (neg_q ? -quo : quo);
          remainder   <= zero_div ? dvd_orig : (neg_r ? -rem : rem);
          div_by_zero <= zero_div;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - self-checking bench for sequential_divider
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: plain 64-bit division, truncating toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end
  endfunction

  int          e = 0;
  int          m_acc = 0;
  bit          m_act = 0;
  bit          chk_en = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_z = 1'b0, p_z = 1'b0;

  // Timing model: accept at edge A, results appear after A+33, done after A+34, next accept at A+35.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      e++;
      if (m_act && e == m_acc + 33) begin
        m_q = p_q; m_r = p_r; m_z = p_z;
      end
      if (start && (!m_act || e >= m_acc + 35)) begin
        m_act = 1; m_acc = e;
        model(dividend, divisor, signed_op, p_q, p_r, p_z);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", {31'b0, busy}, {31'b0, m_act && e >= m_acc + 1 && e <= m_acc + 33});
      chk("done", {31'b0, done}, {31'b0, m_act && e == m_acc + 34});
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_z});
    end
  end

  task automatic finish_op(input int lat0, input logic [31:0] eq, input logic [31:0] er,
                           input logic ez, input string nm);
    int lat, nbusy;
    bit got;
    lat = lat0; nbusy = 0; got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
      if (done) got = 1;
    end
    chk({nm, " seen_done"}, {31'b0, got}, 32'd1);
    chk({nm, " latency"}, lat, 32'd34);
    if (lat0 == 0) chk({nm, " busy_cycles"}, nbusy, 32'd33);
    chk({nm, " q"}, quotient, eq);
    chk({nm, " r"}, remainder, er);
    chk({nm, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] eq, input logic [31:0] er, input logic ez, input string nm);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(0, eq, er, ez, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst q", quotient, 32'd0);
    chk("rst r", remainder, 32'd0);
    chk("rst dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;

    op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u100_7");
    op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s-7_2");
    op(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, "s7_-2");
    op(32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, "sdiv0");
    op(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, "udiv0");
    op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, "sovf");
    op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, "uovf");
    op(32'h80000000, 32'd2, 1'b1, 32'hC0000000, 32'd0, 1'b0, "smin_2");
    op(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, "umax_16");
    op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, "s-100_-7");

    // A second start during CALC, with new operands, must be ignored.
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd999; divisor = 32'd3; signed_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(5, 32'd14, 32'd2, 1'b0, "ignore");

    // start held high through done: next operation accepted on the edge after done.
    dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd81; divisor = 32'd9;
    finish_op(0, 32'd10, 32'd0, 1'b0, "held1");
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(0, 32'd9, 32'd0, 1'b0, "held2");

    // Asynchronous reset mid-operation.
    dividend = 32'd123456; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort q", quotient, 32'd0);
    chk("abort r", remainder, 32'd0);
    chk("abort dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort no_done", nd, 32'd0);
    op(32'd200, 32'd10, 1'b0, 32'd20, 32'd0, 1'b0, "after_abort");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
